activation_buffer: RTL

//  Downstream stage of the layer datapath: captures the serial BIT_SIZE y stream from layer,

---
 rtl/nn_pkg.sv | 16 +
 rtl/activation_buffer_if.sv | 39 +++
 rtl/act_relu.sv | 24 ++
 rtl/activation_buffer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: types and defaults shared by the layer datapath
// (memory, layer and activation stages).
package nn_pkg;

  localparam int BIT_SIZE   = 16;
  localparam int LAYER_SIZE = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  typedef logic signed [BIT_SIZE-1:0] sample_t;

endpackage

// File: rtl/activation_buffer_if.sv
// activation_buffer_if: y capture stream in,
// x replay stream out, plus the layer_done pulse.
interface activation_buffer_if #(
  parameter int BIT_SIZE = nn_pkg::BIT_SIZE
);
  import nn_pkg::*;

  logic signed [BIT_SIZE-1:0] y_in;
  logic                       y_valid;
  logic                       y_ready;
  logic signed [BIT_SIZE-1:0] x_out;
  logic                       x_valid;
  logic                       x_ready;
  logic                       x_last;
  logic                       layer_done;

  modport master (
    output y_in,
    output y_valid,
    input  y_ready,
    input  x_out,
    input  x_valid,
    output x_ready,
    input  x_last,
    input  layer_done
  );

  modport slave (
    input  y_in,
    input  y_valid,
    output y_ready,
    output x_out,
    output x_valid,
    input  x_ready,
    output x_last,
    output layer_done
  );

endinterface

// File: rtl/act_relu.sv
// act_relu: combinational ReLU followed by a signed
// upper clamp; output width equals input width.
module act_relu #(
  parameter int BIT_SIZE = nn_pkg::BIT_SIZE,
  parameter bit RELU_EN  = 1'b1,
  parameter logic signed [BIT_SIZE-1:0] CLAMP_MAX =
    {1'b0, {(BIT_SIZE-1){1'b1}}}
) (
  input  logic signed [BIT_SIZE-1:0] y_i,
  output logic signed [BIT_SIZE-1:0] a_o
);
  import nn_pkg::*;

  logic signed [BIT_SIZE-1:0] v;

  always_comb begin
    v = y_i;
    if (RELU_EN && y_i[BIT_SIZE-1]) begin
      v = '0;
    end
    a_o = (v > CLAMP_MAX) ? CLAMP_MAX : v;
  end

endmodule

// File: rtl/activation_buffer.sv
// activation_buffer: captures activated y vectors into a
// two-bank ping-pong store and replays each full bank as x.
module activation_buffer #(
  parameter int BIT_SIZE   = nn_pkg::BIT_SIZE,
  parameter int LAYER_SIZE = nn_pkg::LAYER_SIZE,
  parameter bit RELU_EN    = 1'b1,
  parameter logic signed [BIT_SIZE-1:0] CLAMP_MAX =
    {1'b0, {(BIT_SIZE-1){1'b1}}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  activation_buffer_if.slave bus
);
  import nn_pkg::*;

  localparam int IDX_W = $clog2(LAYER_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(LAYER_SIZE-1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef logic signed [BIT_SIZE-1:0] word_t;

  word_t            mem_q   [2][LAYER_SIZE];
  word_t            mem_d   [2][LAYER_SIZE];
  bank_state_t      state_q [2];
  bank_state_t      state_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             done_q, done_d;

  word_t act;
  logic  accept;
  logic  xfer;

  act_relu #(
    .BIT_SIZE  (BIT_SIZE),
    .RELU_EN   (RELU_EN),
    .CLAMP_MAX (CLAMP_MAX)
  ) u_relu (
    .y_i (bus.y_in),
    .a_o (act)
  );

  // Handshakes decode the registered state only,
  // so a bank freed this cycle is writable next cycle.
  assign bus.y_ready    = state_q[wr_bank_q] != BANK_FULL;
  assign bus.x_valid    = state_q[rd_bank_q] == BANK_FULL;
  assign bus.x_out      = mem_q[rd_bank_q][rd_idx_q];
  assign bus.x_last     = rd_idx_q == IDX_LAST;
  assign bus.layer_done = done_q;

  assign accept = bus.y_valid & bus.y_ready;
  assign xfer   = bus.x_valid & bus.x_ready;

  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    done_d    = 1'b0;
    if (flush) begin
      for (int b = 0; b < 2; b++) begin
        state_d[b] = BANK_EMPTY;
        for (int i = 0; i < LAYER_SIZE; i++) begin
          mem_d[b][i] = '0;
        end
      end
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
    end else begin
      if (accept) begin
        mem_d[wr_bank_q][wr_idx_q] = act;
        wr_idx_d = wr_idx_q + IDX_ONE;
        if (wr_idx_q == IDX_LAST) begin
          state_d[wr_bank_q] = BANK_FULL;
          wr_bank_d = ~wr_bank_q;
          done_d    = 1'b1;
        end else begin
          state_d[wr_bank_q] = BANK_FILLING;
        end
      end
      if (xfer) begin
        rd_idx_d = rd_idx_q + IDX_ONE;
        if (bus.x_last) begin
          state_d[rd_bank_q] = BANK_EMPTY;
          rd_bank_d = ~rd_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        for (int i = 0; i < LAYER_SIZE; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      done_q    <= done_d;
    end
  end

endmodule
